mem_initiator: RTL and testbench
================================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 The module SHALL take parameter WAIT_CYCLES, default 1, giving the number of cycles a RAM strobe is held asserted (legal range 1..15).
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 req_rd  input  1  read request from the control unit, sampled in IDLE only.
REQ-005 req_wr  input  1  write request from the control unit, sampled in IDLE only.
REQ-006 addr_in  input  32  word address, taken from the bus (MAR value).
REQ-007 wdata_in  input  32  write data (MDR value).
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  one-cycle error pulse, coincident with done.
REQ-011 rdata_out  output  32  registered read data.
REQ-012 ram_read  output  1  RAM read strobe.
REQ-013 ram_write  output  1  RAM write strobe.
REQ-014 ram_address  output  9  RAM address, registered from addr_in[8:0].
REQ-015 ram_wdata  output  32  RAM write data, registered from wdata_in.
REQ-016 ram_rdata  input  32  RAM read data; high-Z whenever ram_read is low.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, SETUP, ACCESS, HOLD and DONE, with a 4-bit wait counter.
REQ-018 In IDLE with req_wr=1 and a valid address, the block SHALL register the address and data and go to SETUP (write takes priority over read).
REQ-019 In IDLE with req_rd=1 and req_wr=0 and a valid address, the block SHALL register the address and go to ACCESS with a read flag set.
REQ-020 When req_rd and req_wr are both 1, the block SHALL perform only the write and SHALL pulse err with done.
REQ-021 When addr_in[31:9] is nonzero on request, the block SHALL issue no strobe, go directly to DONE, pulse done and err, and leave rdata_out unchanged.
REQ-022 SETUP SHALL last one cycle with ram_address and ram_wdata stable and ram_write=0; the next state is ACCESS.
REQ-023 ACCESS SHALL last exactly WAIT_CYCLES cycles, asserting ram_read (read) or ram_write (write) for every one of those cycles.
REQ-024 On the clock edge that leaves a read ACCESS, the block SHALL load ram_rdata into rdata_out; the next state is DONE.
REQ-025 A write ACCESS SHALL exit to HOLD, a one-cycle state with ram_write=0 and address/data unchanged; the next state is DONE.
REQ-026 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE.
REQ-027 ram_address and ram_wdata SHALL change only on the IDLE-exit edge, never while a strobe is high.
REQ-028 ram_read and ram_write SHALL never be high in the same cycle, and both SHALL be decoded from registered state so they are glitch-free.
REQ-029 Requests arriving outside IDLE SHALL be ignored and not queued.
REQ-030 Read latency from the request edge SHALL be WAIT_CYCLES+1 cycles to done; write latency SHALL be WAIT_CYCLES+3 cycles.
REQ-031 A request held high through DONE SHALL be accepted again on the first IDLE cycle, so back-to-back accesses have a one-cycle IDLE gap.

Reset
REQ-032 clear=0 SHALL force IDLE immediately and asynchronously: ram_read=0, ram_write=0, busy=0, done=0, err=0, ram_address=0, ram_wdata=0, rdata_out=0, counter=0.
REQ-033 When reset is asserted mid-ACCESS, the strobe SHALL drop in the same cycle, no rdata_out update SHALL occur, and no done SHALL be issued.

Verification (WAIT_CYCLES=1 unless stated)
REQ-034 Scenario 1: write addr 0x05, data 0xDEADBEEF, then read addr 0x05 -> ram_write high for exactly 1 cycle after SETUP; the read completes with rdata_out=0xDEADBEEF and done 2 cycles after the request.
REQ-035 Scenario 2: WAIT_CYCLES=3, read addr 0x1FF preloaded with 0x12345678 -> ram_read high for 3 cycles; done in cycle 4 with rdata_out=0x12345678.
REQ-036 Scenario 3: req_rd=req_wr=1, addr 0x10, data 0xA5A5A5A5 -> write only, no ram_read pulse, done=err=1, and mem[0x10]=0xA5A5A5A5.
REQ-037 Scenario 4: read addr 0x00000200 -> no strobe, done=err=1 one cycle later, rdata_out unchanged.
REQ-038 Scenario 5: clear pulsed low during a write ACCESS -> ram_write=0 immediately, all outputs 0, and the RAM content for that access is checked as unmodified if the strobe had not yet been sampled.
REQ-039 Scenario 6: req_rd toggled high during busy -> ignored; exactly one done per accepted request.

Source files
------------

// File: rtl/mem_initiator_if.sv
// Control-unit request/status bus plus the RAM strobe/address/data bus of mem_initiator.
// master is the initiator's view; slave is the view of the control unit and RAM together.
interface mem_initiator_if;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata_out;
  logic        ram_read;
  logic        ram_write;
  logic [8:0]  ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (
    input  req_rd, req_wr, addr_in, wdata_in, ram_rdata,
    output busy, done, err, rdata_out, ram_read, ram_write, ram_address, ram_wdata
  );

  modport slave (
    output req_rd, req_wr, addr_in, wdata_in, ram_rdata,
    input  busy, done, err, rdata_out, ram_read, ram_write, ram_address, ram_wdata
  );
endinterface

// File: rtl/mem_initiator.sv
// Single-request RAM initiator: turns a read/write request into a timed strobe sequence
// (SETUP/ACCESS/HOLD) on a 512-word RAM and reports completion with done/err.
module mem_initiator #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic            clock,
  input  logic            clear,
  mem_initiator_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        is_read;
  logic        err_flag;
  logic [8:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic addr_ok;
  logic req_any;
  logic access_end;

  assign addr_ok    = (bus.addr_in[31:9] == '0);
  assign req_any    = bus.req_rd || bus.req_wr;
  assign access_end = (state == ACCESS) && (wait_cnt == LAST_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          if (!addr_ok)        state_nxt = DONE;
          else if (bus.req_wr) state_nxt = SETUP;
          else                 state_nxt = ACCESS;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (access_end) state_nxt = is_read ? DONE : HOLD;
      HOLD:   state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and status decode only registered state, so they cannot glitch on request inputs.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.err       = (state == DONE) && err_flag;
    bus.ram_read  = (state == ACCESS) && is_read;
    bus.ram_write = (state == ACCESS) && !is_read;
  end

  // Address/data capture happens only on the IDLE-exit edge, so they are stable under any strobe.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
      is_read  <= 1'b0;
      err_flag <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        is_read  <= !bus.req_wr;
        err_flag <= !addr_ok || (bus.req_rd && bus.req_wr);
        if (addr_ok) begin
          addr_q <= bus.addr_in[8:0];
          if (bus.req_wr) wdata_q <= bus.wdata_in;
        end
      end

      if (state == ACCESS && !access_end) wait_cnt <= wait_cnt + 4'd1;
      else                                wait_cnt <= '0;

      if (access_end && is_read) rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.ram_address = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.rdata_out   = rdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator: two instances (WAIT_CYCLES=1 and 3) with RAM models;
// stimulus pushes expected completions, a negedge monitor pops them on every done.
module tb_mem_initiator;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic clear1, clear3;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_initiator_if bus1 ();
  mem_initiator_if bus3 ();

  mem_initiator #(.WAIT_CYCLES(1)) dut1 (.clock(clock), .clear(clear1), .bus(bus1));
  mem_initiator #(.WAIT_CYCLES(3)) dut3 (.clock(clock), .clear(clear3), .bus(bus3));

  // RAM models: synchronous write, combinational read while strobed, idle bus reads as zero.
  logic [31:0] mem1 [0:511];
  logic [31:0] mem3 [0:511];

  always @(posedge clock) if (bus1.ram_write) mem1[bus1.ram_address] <= bus1.ram_wdata;
  always @(posedge clock) if (bus3.ram_write) mem3[bus3.ram_address] <= bus3.ram_wdata;
  assign bus1.ram_rdata = bus1.ram_read ? mem1[bus1.ram_address] : '0;
  assign bus3.ram_rdata = bus3.ram_read ? mem3[bus3.ram_address] : '0;

  exp_t        sb [2][$];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt [2];
  int          wr_cnt [2];
  logic [31:0] exp_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor(input int i, input logic done, input logic err,
                         input logic [31:0] rdata, input logic rd, input logic wr);
    exp_t e;
    if (rd) rd_cnt[i]++;
    if (wr) wr_cnt[i]++;
    if (rd && wr) begin
      errors++;
      $display("FAIL d%0d_strobe_overlap at cycle %0d", i, cyc);
    end
    if (err && !done) begin
      errors++;
      $display("FAIL d%0d_err_without_done at cycle %0d", i, cyc);
    end
    if (done) begin
      if (sb[i].size() == 0) begin
        errors++;
        $display("FAIL d%0d_unexpected_done at cycle %0d", i, cyc);
      end else begin
        e = sb[i].pop_front();
        check($sformatf("d%0d_done_cycle", i), cyc, e.due);
        check($sformatf("d%0d_err", i), {31'b0, err}, {31'b0, e.err});
        check($sformatf("d%0d_rdata_out", i), rdata, e.rdata);
      end
    end
  endtask

  always @(negedge clock) begin
    monitor(0, bus1.done, bus1.err, bus1.rdata_out, bus1.ram_read, bus1.ram_write);
    monitor(1, bus3.done, bus3.err, bus3.rdata_out, bus3.ram_read, bus3.ram_write);
  end

  task automatic drive(input int i, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      bus1.req_rd = rd; bus1.req_wr = wr; bus1.addr_in = a; bus1.wdata_in = d;
    end else begin
      bus3.req_rd = rd; bus3.req_wr = wr; bus3.addr_in = a; bus3.wdata_in = d;
    end
  endtask

  // Present a request in cycle r, hold it for 'hold' rising edges, and optionally
  // expect its completion 'lat' cycles after the request cycle.
  task automatic request(input int i, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input int hold,
                         input bit push, input logic e_err, input logic [31:0] e_rd,
                         input int lat, output int r);
    @(negedge clock);
    r = cyc;
    drive(i, rd, wr, a, d);
    @(posedge clock);
    #1;
    if (push) sb[i].push_back(exp_t'{err: e_err, rdata: e_rd, due: r + lat});
    for (int k = 1; k < hold; k++) @(posedge clock);
    #1;
    drive(i, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_idle(input int i);
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clock);
      ok = (i == 0 ? !bus1.busy : !bus3.busy) && (sb[i].size() == 0);
    end
    if (!ok) begin
      errors++;
      $display("FAIL d%0d_idle_timeout at cycle %0d", i, cyc);
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 2; k++) begin
      rd_cnt[k] = 0;
      wr_cnt[k] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int k = 0; k < 512; k++) begin
      mem1[k] = '0;
      mem3[k] = '0;
    end
    mem3[9'h1FF] = 32'h1234_5678;
    mem1[9'h020] = 32'hCAFE_F00D;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    clr_counts();
    clear1 = 1'b0;
    clear3 = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    #1;
    check("rst_busy",        {31'b0, bus1.busy},      '0);
    check("rst_done",        {31'b0, bus1.done},      '0);
    check("rst_err",         {31'b0, bus1.err},       '0);
    check("rst_ram_read",    {31'b0, bus1.ram_read},  '0);
    check("rst_ram_write",   {31'b0, bus1.ram_write}, '0);
    check("rst_ram_address", {23'b0, bus1.ram_address}, '0);
    check("rst_ram_wdata",   bus1.ram_wdata,          '0);
    check("rst_rdata_out",   bus1.rdata_out,          '0);
    check("rst_busy_d3",     {31'b0, bus3.busy},      '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear1 = 1'b1;
    clear3 = 1'b1;

    // Write 0x05 <- DEADBEEF then read it back: write W+3, read W+1.
    clr_counts();
    request(0, 1'b0, 1'b1, 32'h5, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, exp_rd[0], 4, r);
    wait_idle(0);
    check("s1_wr_strobes", wr_cnt[0], 1);
    check("s1_rd_strobes", rd_cnt[0], 0);
    check("s1_mem5", mem1[5], 32'hDEAD_BEEF);
    clr_counts();
    exp_rd[0] = 32'hDEAD_BEEF;
    request(0, 1'b1, 1'b0, 32'h5, '0, 1, 1'b1, 1'b0, exp_rd[0], 2, r);
    wait_idle(0);
    check("s1r_rd_strobes", rd_cnt[0], 1);
    check("s1r_wr_strobes", wr_cnt[0], 0);

    // WAIT_CYCLES=3: read 0x1FF, then a write to 0x1FE.
    clr_counts();
    exp_rd[1] = 32'h1234_5678;
    request(1, 1'b1, 1'b0, 32'h1FF, '0, 1, 1'b1, 1'b0, exp_rd[1], 4, r);
    wait_idle(1);
    check("s2_rd_strobes", rd_cnt[1], 3);
    clr_counts();
    request(1, 1'b0, 1'b1, 32'h1FE, 32'h0BAD_CAFE, 1, 1'b1, 1'b0, exp_rd[1], 6, r);
    wait_idle(1);
    check("s2_wr_strobes", wr_cnt[1], 3);
    check("s2_rd_strobes_w", rd_cnt[1], 0);
    check("s2_mem1fe", mem3[9'h1FE], 32'h0BAD_CAFE);

    // Simultaneous read and write: write only, err with done.
    clr_counts();
    request(0, 1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 1, 1'b1, 1'b1, exp_rd[0], 4, r);
    wait_idle(0);
    check("s3_rd_strobes", rd_cnt[0], 0);
    check("s3_wr_strobes", wr_cnt[0], 1);
    check("s3_mem10", mem1[9'h10], 32'hA5A5_A5A5);

    // Out-of-range addresses: no strobe, done+err one cycle later, rdata_out kept.
    clr_counts();
    request(0, 1'b1, 1'b0, 32'h0000_0200, '0, 1, 1'b1, 1'b1, exp_rd[0], 1, r);
    wait_idle(0);
    request(0, 1'b0, 1'b1, 32'h8000_0005, 32'h5555_5555, 1, 1'b1, 1'b1, exp_rd[0], 1, r);
    wait_idle(0);
    check("s4_rd_strobes", rd_cnt[0], 0);
    check("s4_wr_strobes", wr_cnt[0], 0);
    check("s4_mem5_kept", mem1[5], 32'hDEAD_BEEF);

    // Request held through busy is ignored (drops before IDLE).
    clr_counts();
    exp_rd[0] = 32'hA5A5_A5A5;
    request(0, 1'b1, 1'b0, 32'h10, '0, 3, 1'b1, 1'b0, exp_rd[0], 2, r);
    wait_idle(0);
    check("s6_rd_strobes", rd_cnt[0], 1);

    // Request held into IDLE is re-accepted after a one-cycle gap.
    clr_counts();
    exp_rd[0] = 32'hDEAD_BEEF;
    request(0, 1'b1, 1'b0, 32'h5, '0, 4, 1'b1, 1'b0, exp_rd[0], 2, r);
    sb[0].push_back(exp_t'{err: 1'b0, rdata: exp_rd[0], due: r + 5});
    wait_idle(0);
    check("b2b_rd_strobes", rd_cnt[0], 2);

    // Reset during write ACCESS, before the strobe is sampled by the RAM.
    request(0, 1'b0, 1'b1, 32'h20, 32'h1111_1111, 1, 1'b0, 1'b0, '0, 0, r);
    @(posedge clock);
    #2;
    check("s5_strobe_before_clear", {31'b0, bus1.ram_write}, 32'd1);
    clear1 = 1'b0;
    #1;
    check("s5_ram_write",   {31'b0, bus1.ram_write},   '0);
    check("s5_ram_read",    {31'b0, bus1.ram_read},    '0);
    check("s5_busy",        {31'b0, bus1.busy},        '0);
    check("s5_done",        {31'b0, bus1.done},        '0);
    check("s5_err",         {31'b0, bus1.err},         '0);
    check("s5_ram_address", {23'b0, bus1.ram_address}, '0);
    check("s5_ram_wdata",   bus1.ram_wdata,            '0);
    check("s5_rdata_out",   bus1.rdata_out,            '0);
    @(posedge clock);
    @(negedge clock);
    clear1 = 1'b1;
    exp_rd[0] = '0;
    check("s5_mem20_kept", mem1[9'h20], 32'hCAFE_F00D);
    repeat (3) @(negedge clock);
    check("s5_idle_after", {31'b0, bus1.busy}, '0);

    // Normal operation resumes after reset.
    exp_rd[0] = 32'hCAFE_F00D;
    request(0, 1'b1, 1'b0, 32'h20, '0, 1, 1'b1, 1'b0, exp_rd[0], 2, r);
    wait_idle(0);

    check("sb0_drained", sb[0].size(), 0);
    check("sb1_drained", sb[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
